// File: rtl/rpsc_card12_sequencer.sv
// Supervisory sequencer for one card's fault flip-flop bank.
// It debounces the ack/test buttons, drives the bank reset and lamp test, and latches the first-out fault.
//   state  | meaning
//   IDLE   | waiting for a button request; first-out capture armed
//   CLEAR  | ff_reset pulse to the bank
//   SETTLE | blanking after the clear; faults ignored
//   TEST   | la_test asserted; an ack request aborts into CLEAR
module rpsc_card12_sequencer #(
  parameter int N_FAULT          = 8,
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int CLR_PULSE_CYCLES = 4,
  parameter int SETTLE_CYCLES    = 2,
  parameter int LAMP_TEST_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ack_btn,
  input  logic               test_btn,
  input  logic [N_FAULT-1:0] fault_in,
  output logic               ff_reset,
  output logic               la_test,
  output logic [2:0]         first_fault,
  output logic               first_valid,
  output logic               summary_alarm,
  output logic               busy
);

  localparam int CNT_MAX_A = (CLR_PULSE_CYCLES > SETTLE_CYCLES) ? CLR_PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_MAX   = (LAMP_TEST_CYCLES > CNT_MAX_A) ? LAMP_TEST_CYCLES : CNT_MAX_A;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int DB_W      = $clog2(DEBOUNCE_CYCLES + 1);

  generate
    if (N_FAULT > 8) begin : g_bad_n_fault
      $error("rpsc_card12_sequencer: N_FAULT above 8 does not fit first_fault");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SETTLE, S_TEST} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]         w_btn;
  logic [1:0]         r_sync1, r_sync2, r_db, r_db_d;
  logic [DB_W-1:0]    r_db_cnt [2];
  logic               w_ack_req, w_test_req;
  logic [2:0]         w_low_idx;
  logic               w_any_fault;
  logic               r_ff_reset, r_la_test, r_busy, r_first_valid, r_summary;
  logic [2:0]         r_first_fault;

  // bit 0 = ack, bit 1 = lamp test
  assign w_btn = {test_btn, ack_btn};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_db        <= '0;
      r_db_d      <= '0;
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] == r_db[b]) begin
          r_db_cnt[b] <= '0;
        end else if (r_db_cnt[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_db[b]     <= r_sync2[b];
          r_db_cnt[b] <= '0;
        end else begin
          r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
        end
      end
    end
  end

  assign w_ack_req  = r_db[0] & ~r_db_d[0];
  assign w_test_req = r_db[1] & ~r_db_d[1];

  always_comb begin
    w_low_idx = '0;
    for (int i = N_FAULT - 1; i >= 0; i--) begin
      if (fault_in[i]) w_low_idx = 3'(i);
    end
  end

  assign w_any_fault = |fault_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Timers count down to zero and hold there; the zero cycle is the last counted one.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_ack_req) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = CNT_W'(CLR_PULSE_CYCLES - 1);
        end else if (w_test_req) begin
          w_state_nxt = S_TEST;
          w_cnt_nxt   = CNT_W'(LAMP_TEST_CYCLES - 1);
        end
      end
      S_CLEAR: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      S_TEST: begin
        if (w_ack_req) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = CNT_W'(CLR_PULSE_CYCLES - 1);
        end else if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ff_reset    <= 1'b0;
      r_la_test     <= 1'b0;
      r_busy        <= 1'b0;
      r_summary     <= 1'b0;
      r_first_valid <= 1'b0;
      r_first_fault <= '0;
    end else begin
      r_ff_reset <= (w_state_nxt == S_CLEAR);
      r_la_test  <= (w_state_nxt == S_TEST);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_summary  <= w_any_fault;
      // Entering CLEAR wipes the first-out record even if a fault arrives that same cycle.
      if (w_state_nxt == S_CLEAR && r_state != S_CLEAR) begin
        r_first_valid <= 1'b0;
        r_first_fault <= '0;
      end else if ((r_state == S_IDLE || r_state == S_TEST) && !r_first_valid && w_any_fault) begin
        r_first_valid <= 1'b1;
        r_first_fault <= w_low_idx;
      end
    end
  end

  assign ff_reset      = r_ff_reset;
  assign la_test       = r_la_test;
  assign busy          = r_busy;
  assign summary_alarm = r_summary;
  assign first_valid   = r_first_valid;
  assign first_fault   = r_first_fault;

endmodule
